// File: rtl/adder_preimage_enum_pkg.sv
// Shared types and helpers for the adder preimage enumerator: FSM states,
// candidate count and the per-target triple count rule.
package adder_enum_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

   localparam int W_DEFAULT = 3;
   localparam int NUM_CAND  = 1 << (W_DEFAULT + 1);

   // Number of (x, y) pairs of w-bit values with x + y == t.
   function automatic int pair_count(input int t, input int w);
      int top;
      top = 1 << w;
      if (t >= 0 && t <= top - 1)
         return t + 1;
      else if (t >= top && t <= 2 * top - 2)
         return 2 * top - 1 - t;
      else
         return 0;
   endfunction

   function automatic int preimage_count(input int s, input int w);
      return pair_count(s, w) + pair_count(s - 1, w);
   endfunction

endpackage

// File: rtl/adder_preimage_enum_if.sv
// Target-in / triple-out bus of the adder preimage enumerator.
interface adder_preimage_enum_if #(parameter int W = 3);

   // Both channels: a transfer happens on a rising edge where valid && ready;
   // the producer holds valid and payload stable until that edge.
   logic         in_valid;
   logic         in_ready;
   logic [W:0]   in_sum;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic         out_cin;
   logic         out_last;
   logic [W:0]   out_count;

   modport master (
      output in_valid, in_sum, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_cin, out_last, out_count
   );

   modport slave (
      input  in_valid, in_sum, out_ready,
      output in_ready, out_valid, out_a, out_b, out_cin, out_last, out_count
   );

endinterface

// File: rtl/adder_preimage_enum_cand.sv
// Combinational candidate evaluator: index i = {cin, a} against target s,
// producing b = s - a - cin and whether b fits in W bits.
module adder_enum_cand #(
   parameter int W = 3
) (
   input  logic [W:0]   s,
   input  logic [W:0]   i,
   output logic         hit,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic         cin
);

   logic [W+1:0] diff;

   always_comb begin
      a    = i[W-1:0];
      cin  = i[W];
      diff = {1'b0, s} - {2'b00, i[W-1:0]} - {{(W+1){1'b0}}, i[W]};
      // Non-negative and below 2^W means both top bits are clear.
      hit  = (diff[W+1:W] == 2'b00);
      b    = diff[W-1:0];
   end

endmodule

// File: rtl/adder_preimage_enum.sv
// Streams every (a, b, cin) with a + b + cin == target, in {cin, a} order,
// one registered triple per handshake with a last flag and total count.
module adder_preimage_enum
   import adder_enum_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_preimage_enum_if.slave  bus,
   output state_e                dbg_state
);

   localparam int         CW  = W + 1;
   localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

   state_e       state_q, state_d;
   logic [W:0]   sum_q, sum_d;
   logic [W:0]   idx_q, idx_d;
   logic [W:0]   emitted_q, emitted_d;
   logic [W:0]   count_q, count_d;
   logic         out_valid_q, out_valid_d;
   logic         out_last_q, out_last_d;
   logic         out_cin_q, out_cin_d;
   logic [W-1:0] out_a_q, out_a_d;
   logic [W-1:0] out_b_q, out_b_d;

   logic         cand_hit;
   logic         cand_cin;
   logic [W-1:0] cand_a;
   logic [W-1:0] cand_b;

   adder_enum_cand #(.W(W)) u_cand (
      .s   (sum_q),
      .i   (idx_q),
      .hit (cand_hit),
      .a   (cand_a),
      .b   (cand_b),
      .cin (cand_cin)
   );

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      emitted_d   = emitted_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_cin_d   = out_cin_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sum_d     = bus.in_sum;
               count_d   = CW'(preimage_count(int'(bus.in_sum), W));
               idx_d     = '0;
               emitted_d = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (cand_hit) begin
               out_a_d     = cand_a;
               out_b_d     = cand_b;
               out_cin_d   = cand_cin;
               out_valid_d = 1'b1;
               out_last_d  = ((emitted_q + ONE) == count_q);
               state_d     = EMIT;
            end else begin
               idx_d = idx_q + ONE;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               emitted_d   = emitted_q + ONE;
               if (out_last_q) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + ONE;
                  state_d = SCAN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         idx_q       <= '0;
         emitted_q   <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_cin_q   <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         emitted_q   <= emitted_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_cin_q   <= out_cin_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
      end
   end

   // Ready is a decode of the state register only, never of in_valid.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;
   assign bus.out_cin   = out_cin_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_count = count_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_adder_preimage_enum.sv
// Bench for adder_preimage_enum: directed targets plus random targets with
// random backpressure, checked against an enumerate-all-triples model.
module tb_adder_preimage_enum;
   import adder_enum_pkg::*;

   localparam int W = 3;

   logic   clk = 1'b0;
   logic   rst;
   state_e dbg_state;
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;

   logic [6:0] exp_q[$];

   adder_preimage_enum_if #(.W(W)) bus ();

   adder_preimage_enum #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every triple with a + b + cin == s, cin outer and a inner, both ascending.
   task automatic build_model(input int s);
      exp_q.delete();
      for (int cin = 0; cin < 2; cin++) begin
         for (int a = 0; a < (1 << W); a++) begin
            int b;
            b = s - a - cin;
            if (b >= 0 && b < (1 << W))
               exp_q.push_back({3'(a), 3'(b), 1'(cin)});
         end
      end
   endtask

   task automatic stream(input logic [W:0] s, input int exp_n_in, input bit bp,
                         input bit poke, input int limit, input int exp_lat);
      int         k;
      int         t0;
      int         wait_c;
      int         cyc_in;
      int         exp_n;
      bit         held;
      bit         lat_done;
      logic [7:0] hold;
      logic [6:0] e;
      build_model(int'(s));
      exp_n = (exp_n_in < 0) ? exp_q.size() : exp_n_in;
      wait_c = 0;
      while (bus.in_ready !== 1'b1 && wait_c < 50) begin
         @(negedge clk);
         wait_c++;
      end
      check("in_ready_before_offer", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_sum    = s;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      t0 = cyc;
      check("count_after_accept", bus.out_count, exp_n);
      k = 0; held = 0; lat_done = 0; cyc_in = 0; wait_c = 0;
      while (k < limit && k < exp_n) begin
         cyc_in++;
         wait_c++;
         if (wait_c > 60) begin
            check("timeout_waiting_triple", k, exp_n);
            break;
         end
         bus.in_valid = poke && (cyc_in == 4);
         bus.in_sum   = (poke && cyc_in == 4) ? 4'd3 : s;
         check("valid_and_ready", bus.out_valid && bus.in_ready, 0);
         if (bus.out_valid === 1'b1) begin
            if (!lat_done && exp_lat >= 0) begin
               check("first_latency", cyc - t0, exp_lat);
            end
            lat_done = 1;
            if (held) begin
               check("stall_stable", {bus.out_a, bus.out_b, bus.out_cin, bus.out_last}, hold);
               check("stall_count", bus.out_count, exp_n);
            end
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_ready) begin
               e = exp_q[k];
               check("out_a", bus.out_a, e[6:4]);
               check("out_b", bus.out_b, e[3:1]);
               check("out_cin", bus.out_cin, e[0]);
               check("out_last", bus.out_last, (k == exp_n - 1));
               check("out_count", bus.out_count, exp_n);
               k++;
               held = 0;
               wait_c = 0;
               @(negedge clk);
               bus.out_ready = 1'b0;
               bus.in_valid  = 1'b0;
               check("valid_drop", bus.out_valid, 0);
               check("in_ready_after", bus.in_ready, (k == exp_n));
               continue;
            end
            held = 1;
            hold = {bus.out_a, bus.out_b, bus.out_cin, bus.out_last};
         end else begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_operands", {bus.out_a, bus.out_b, bus.out_cin}, 0);
      check("rst_out_count", bus.out_count, 0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b0;
      @(negedge clk);

      stream(4'd0, 1, 1'b0, 1'b0, 99, 1);
      stream(4'd15, 1, 1'b0, 1'b0, 99, 16);
      stream(4'd7, 15, 1'b0, 1'b0, 99, -1);
      stream(4'd8, 15, 1'b1, 1'b0, 99, 2);
      stream(4'd8, 15, 1'b1, 1'b1, 99, 2);

      stream(4'd7, 15, 1'b0, 1'b0, 4, -1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_count", bus.out_count, 0);
      rst = 1'b0;
      @(negedge clk);
      stream(4'd1, 3, 1'b0, 1'b0, 99, 1);

      for (int r = 0; r < 6; r++) begin
         stream(4'($urandom_range(0, NUM_CAND - 1)), -1, 1'b1, 1'b0, 99, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
